// File: rtl/psg_bus_sequencer_pkg.sv
// Shared types for the PSG bus sequencer: request record, FSM states and
// the BDIR/BC phase codes driven onto the AY-3-8913/YM2149 bus.
package psg_bus_pkg;

  typedef struct packed {
    logic       rd;
    logic [3:0] regnum;
    logic [7:0] data;
  } psg_req_t;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    LATCH,
    INACT1,
    WRITE,
    READ,
    INACT2
  } psg_state_t;

  // {BDIR, BC}
  localparam logic [1:0] CODE_INACT = 2'b00;
  localparam logic [1:0] CODE_READ  = 2'b01;
  localparam logic [1:0] CODE_WRITE = 2'b10;
  localparam logic [1:0] CODE_LATCH = 2'b11;

  function automatic logic [1:0] bus_code(psg_state_t s);
    case (s)
      LATCH:   return CODE_LATCH;
      WRITE:   return CODE_WRITE;
      READ:    return CODE_READ;
      default: return CODE_INACT;
    endcase
  endfunction

endpackage

// File: rtl/psg_bus_sequencer_if.sv
// Request/response channel between a sound source and the PSG bus sequencer.
interface psg_bus_sequencer_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_rd_i;
  logic [3:0] req_reg_i;
  logic [7:0] req_data_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_data_o;

  modport master (
    output req_valid_i, req_rd_i, req_reg_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_rd_i, req_reg_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/psg_bus_sequencer_req_fifo.sv
// Synchronous request FIFO; ready is derived from the registered count only,
// so a pop in a full cycle frees space starting the following cycle.
module psg_req_fifo
  import psg_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  psg_req_t                 wdata,
  input  logic                     pop,
  output psg_req_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  psg_req_t        mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/psg_bus_sequencer.sv
// Drives the YM2149 BDIR/BC/DA bus from queued register requests, one bus
// phase per HOLD_CES chip-clock enables, and sequences the PSG reset line.
module psg_bus_sequencer
  import psg_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CES   = 1,
  parameter int RESET_CES  = 8
) (
  input  logic                clk_logic,
  input  logic                reset,
  input  logic                ce_i,
  psg_bus_sequencer_if.slave  req,
  input  logic                psg_reset_req_i,
  output logic                psg_reset_n_o,
  output logic                psg_bdir_o,
  output logic                psg_bc_o,
  output logic [7:0]          psg_da_o,
  input  logic [7:0]          psg_di_i,
  output logic                busy_o
);
  localparam int CNT_MAX = (RESET_CES > HOLD_CES) ? RESET_CES : HOLD_CES;
  localparam int CW      = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
  localparam int QW      = $clog2(FIFO_DEPTH) + 1;

  psg_state_t     state;
  psg_state_t     state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  limit;
  logic           advance;
  logic           pending;
  logic           clr_pending;
  logic           pop;
  logic           cur_rd;
  logic [7:0]     cur_data;
  psg_req_t       head;
  psg_req_t       push_req;
  logic           fifo_full;
  logic           fifo_empty;
  logic [QW-1:0]  fifo_count;

  assign push_req = '{rd: req.req_rd_i, regnum: req.req_reg_i, data: req.req_data_i};

  psg_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_logic),
    .rst   (reset),
    .push  (req.req_valid_i),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign req.req_ready_o = !fifo_full;
  assign busy_o          = (state != IDLE) || (fifo_count != '0) || pending;

  // The reset hold uses the same phase counter with a longer terminal count.
  assign limit   = (state == RST_HOLD) ? CW'(RESET_CES - 1) : CW'(HOLD_CES - 1);
  assign advance = ce_i && (cnt == limit);

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    clr_pending = 1'b0;
    case (state)
      RST_HOLD: if (advance) state_nxt = IDLE;
      IDLE: begin
        if (pending) begin
          state_nxt   = RST_HOLD;
          clr_pending = 1'b1;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = LATCH;
        end
      end
      LATCH:   if (advance) state_nxt = INACT1;
      INACT1:  if (advance) state_nxt = cur_rd ? READ : WRITE;
      WRITE:   if (advance) state_nxt = INACT2;
      READ:    if (advance) state_nxt = INACT2;
      INACT2:  if (advance) state_nxt = IDLE;
      default: state_nxt = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state           <= RST_HOLD;
      cnt             <= '0;
      pending         <= 1'b0;
      psg_reset_n_o   <= 1'b0;
      psg_bdir_o      <= 1'b0;
      psg_bc_o        <= 1'b0;
      psg_da_o        <= '0;
      req.rsp_valid_o <= 1'b0;
      req.rsp_data_o  <= '0;
    end else begin
      state <= state_nxt;
      if (state != IDLE && ce_i) cnt <= advance ? '0 : cnt + 1'b1;
      // A request arriving while the flag is being consumed re-arms it.
      if (psg_reset_req_i)  pending <= 1'b1;
      else if (clr_pending) pending <= 1'b0;
      psg_reset_n_o            <= (state_nxt != RST_HOLD);
      {psg_bdir_o, psg_bc_o}   <= bus_code(state_nxt);
      if (pop)                             psg_da_o <= {4'h0, head.regnum};
      else if (state == INACT1 && advance) psg_da_o <= cur_rd ? 8'h00 : cur_data;
      req.rsp_valid_o <= (state == READ) && advance;
      if (state == READ && advance) req.rsp_data_o <= psg_di_i;
    end
  end

  always_ff @(posedge clk_logic) begin
    if (pop) begin
      cur_rd   <= head.rd;
      cur_data <= head.data;
    end
  end

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Bench for psg_bus_sequencer: a small YM2149 register model on the bus and a
// request-level reference model of expected writes and read responses.
`timescale 1ns/1ps
module tb_psg_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       ce3_en = 1'b1;
  logic       ce3;
  logic       rst_req = 1'b0;
  logic       rst_req3 = 1'b0;
  logic       psg_reset_n, bdir, bc, busy;
  logic [7:0] da, di;
  logic       reset_n3, bdir3, bc3, busy3;
  logic [7:0] da3;

  psg_bus_sequencer_if ifc ();
  psg_bus_sequencer_if ifc3 ();

  int checks = 0;
  int failures = 0;

  assign ce3 = ce & ce3_en;

  psg_bus_sequencer #(.FIFO_DEPTH(4), .HOLD_CES(1), .RESET_CES(8)) dut (
    .clk_logic(clk), .reset(reset), .ce_i(ce), .req(ifc),
    .psg_reset_req_i(rst_req), .psg_reset_n_o(psg_reset_n),
    .psg_bdir_o(bdir), .psg_bc_o(bc), .psg_da_o(da), .psg_di_i(di),
    .busy_o(busy)
  );

  psg_bus_sequencer #(.FIFO_DEPTH(4), .HOLD_CES(3), .RESET_CES(8)) dut3 (
    .clk_logic(clk), .reset(reset), .ce_i(ce3), .req(ifc3),
    .psg_reset_req_i(rst_req3), .psg_reset_n_o(reset_n3),
    .psg_bdir_o(bdir3), .psg_bc_o(bc3), .psg_da_o(da3), .psg_di_i(8'h00),
    .busy_o(busy3)
  );

  initial forever #5 clk = ~clk;

  // 1-in-14 chip clock enable, changed on the falling edge
  initial begin : ce_gen
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n  = (n == 13) ? 0 : n + 1;
      ce = (n == 13);
    end
  end

  // YM2149 register model and reference-model state
  logic [7:0]  psg_regs [16];
  logic [3:0]  psg_addr = 4'h0;
  logic [7:0]  ref_regs [16];
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_rsp [$];
  logic [10:0] blog [$];
  logic [9:0]  blog3 [$];
  logic [15:0] events [$];
  int          rst_run = 0;
  int          rsp_pulses = 0;
  logic        prev_rst_n = 1'b1;
  logic [1:0]  prev_code = 2'b00;

  assign di = ({bdir, bc} == 2'b01) ? psg_regs[psg_addr] : 8'hFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples just before each rising edge: what the PSG sees on a CE edge.
  initial begin : mon
    for (int i = 0; i < 16; i++) psg_regs[i] = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && ifc.rsp_valid_o) begin
        rsp_pulses++;
        chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
        if (exp_rsp.size() != 0) chk("rsp_data", ifc.rsp_data_o, exp_rsp.pop_front());
      end
      if (!reset && ce3) blog3.push_back({bdir3, bc3, da3});
      if (!reset && ce) begin
        blog.push_back({psg_reset_n, bdir, bc, da});
        if (!psg_reset_n) begin
          if (prev_rst_n) begin
            events.push_back(16'h2000);
            rst_run = 0;
          end
          rst_run++;
          for (int i = 0; i < 16; i++) psg_regs[i] = 8'h00;
          psg_addr = 4'h0;
        end else begin
          if ({bdir, bc} == 2'b11) psg_addr = da[3:0];
          if ({bdir, bc} == 2'b10 && prev_code != 2'b10) begin
            psg_regs[psg_addr] = da;
            events.push_back({4'h1, psg_addr, da});
            chk("wr_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) chk("wr_order", {psg_addr, da}, exp_wr.pop_front());
          end
        end
        prev_rst_n = psg_reset_n;
        prev_code  = {bdir, bc};
      end
    end
  end

  task automatic push(input logic rd, input logic [3:0] r, input logic [7:0] d, output int waited);
    ifc.req_valid_i = 1'b1;
    ifc.req_rd_i    = rd;
    ifc.req_reg_i   = r;
    ifc.req_data_i  = d;
    waited = 0;
    while (!ifc.req_ready_o && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("push_ready", 32'(ifc.req_ready_o), 1);
    if (rd) exp_rsp.push_back(ref_regs[r]);
    else begin
      ref_regs[r] = d;
      exp_wr.push_back({r, d});
    end
    @(negedge clk);
    ifc.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic wait_code(input logic [1:0] code, input string tag);
    int n;
    n = 0;
    while ({bdir, bc} != code && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_code"}, {bdir, bc}, code);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w, n, ev0, p0;
    logic [12:0] snap;
    logic [1:0]  rc [$];
    int          rl [$];

    ifc.req_valid_i = 1'b0; ifc.req_rd_i = 1'b0; ifc.req_reg_i = 4'h0; ifc.req_data_i = 8'h00;
    ifc3.req_valid_i = 1'b0; ifc3.req_rd_i = 1'b0; ifc3.req_reg_i = 4'h0; ifc3.req_data_i = 8'h00;
    for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_reset_n", psg_reset_n, 0);
    chk("rst_code", {bdir, bc}, 2'b00);
    chk("rst_da", da, 8'h00);
    chk("rst_rsp_valid", ifc.rsp_valid_o, 0);
    chk("rst_rsp_data", ifc.rsp_data_o, 8'h00);
    chk("rst_busy", busy, 1);
    chk("rst_ready", ifc.req_ready_o, 1);
    @(negedge clk);
    wait_idle("por");
    chk("por_low_ces", rst_run, 8);
    chk("por_reset_n", psg_reset_n, 1);

    // Single write R7=0x38: one CE per phase
    blog.delete();
    push(1'b0, 4'h7, 8'h38, w);
    wait_idle("r7");
    while (blog.size() > 0 && blog[0][9:8] == 2'b00) void'(blog.pop_front());
    chk("r7_phases", blog.size(), 4);
    chk("r7_latch", blog[0], 11'h707);
    chk("r7_inact1", blog[1], 11'h407);
    chk("r7_write", blog[2], 11'h638);
    chk("r7_inact2", blog[3][10:8], 3'b100);
    chk("r7_psg", psg_regs[7], 8'h38);

    // Write then read back R0
    p0 = rsp_pulses;
    push(1'b0, 4'h0, 8'h5A, w);
    push(1'b1, 4'h0, 8'h00, w);
    wait_idle("r0");
    chk("r0_pulses", rsp_pulses - p0, 1);
    chk("r0_data", ifc.rsp_data_o, 8'h5A);

    // Fill the FIFO while a transaction is in flight
    push(1'b0, 4'h1, 8'h11, w);
    repeat (3) @(negedge clk);
    push(1'b0, 4'h2, 8'h22, w);
    push(1'b0, 4'h3, 8'h33, w);
    push(1'b0, 4'h4, 8'h44, w);
    push(1'b0, 4'h5, 8'h55, w);
    chk("full_ready", ifc.req_ready_o, 0);
    push(1'b0, 4'h6, 8'h66, w);
    chk("fifth_waited", 32'(w > 0), 1);
    wait_idle("burst");

    // Randomized mix of reads and writes
    for (int k = 0; k < 24; k++) begin
      logic       rd;
      logic [3:0] r;
      logic [7:0] d;
      rd = ($urandom_range(0, 2) == 0);
      r  = 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      push(rd, r, d, w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("rand");
    chk("rand_wr_drained", exp_wr.size(), 0);
    chk("rand_rsp_drained", exp_rsp.size(), 0);
    for (int i = 0; i < 16; i++) chk("rand_psg_reg", {i[7:0], psg_regs[i]}, {i[7:0], ref_regs[i]});

    // Reset request during a write: write finishes, reset, then queued write
    ev0 = events.size();
    push(1'b0, 4'h8, 8'h0F, w);
    push(1'b0, 4'h9, 8'hC3, w);
    wait_code(2'b10, "r8");
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
    wait_idle("r8");
    chk("r8_events", events.size() - ev0, 3);
    chk("r8_first", events[ev0], 16'h180F);
    chk("r8_reset", events[ev0 + 1], 16'h2000);
    chk("r8_then_r9", events[ev0 + 2], 16'h19C3);
    chk("r8_reset_ces", rst_run, 8);
    chk("r8_psg_r9", psg_regs[9], 8'hC3);

    // HOLD_CES=3 instance: freeze mid-LATCH, then every phase spans 3 CEs
    n = 0;
    while (busy3 && n < 5000) begin @(negedge clk); n++; end
    chk("h3_por_idle", busy3, 0);
    blog3.delete();
    ifc3.req_valid_i = 1'b1; ifc3.req_rd_i = 1'b0; ifc3.req_reg_i = 4'h3; ifc3.req_data_i = 8'hA5;
    chk("h3_ready", ifc3.req_ready_o, 1);
    @(negedge clk);
    ifc3.req_valid_i = 1'b0;
    n = 0;
    while (!(blog3.size() > 0 && blog3[blog3.size() - 1][9:8] == 2'b11) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("h3_in_latch", {bdir3, bc3}, 2'b11);
    ce3_en = 1'b0;
    snap = {bdir3, bc3, da3, busy3, reset_n3};
    repeat (40) @(negedge clk);
    chk("h3_frozen", {bdir3, bc3, da3, busy3, reset_n3}, snap);
    ce3_en = 1'b1;
    n = 0;
    while (busy3 && n < 5000) begin @(negedge clk); n++; end
    chk("h3_done", busy3, 0);
    while (blog3.size() > 0 && blog3[0][9:8] == 2'b00) void'(blog3.pop_front());
    chk("h3_latch_da", blog3[0][7:0], 8'h03);
    for (int i = 0; i < blog3.size(); i++) begin
      if (i == 0 || blog3[i][9:8] != blog3[i - 1][9:8]) begin
        rc.push_back(blog3[i][9:8]);
        rl.push_back(1);
        if (blog3[i][9:8] == 2'b10) chk("h3_write_da", blog3[i][7:0], 8'hA5);
      end else rl[rl.size() - 1]++;
    end
    chk("h3_runs", rc.size(), 4);
    for (int i = 0; i < 4 && i < rc.size(); i++) begin
      chk("h3_run_code", rc[i], (i == 0) ? 2'b11 : (i == 2) ? 2'b10 : 2'b00);
      chk("h3_run_len", rl[i], 3);
    end

    // Reset asserted during READ aborts without a response
    push(1'b1, 4'h9, 8'h00, w);
    wait_code(2'b01, "rdabort");
    p0 = rsp_pulses;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_code", {bdir, bc}, 2'b00);
    chk("abort_reset_n", psg_reset_n, 0);
    chk("abort_rsp_valid", ifc.rsp_valid_o, 0);
    reset = 1'b0;
    exp_rsp.delete();
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", rsp_pulses - p0, 0);
    chk("abort_ready", ifc.req_ready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
